// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end sharing one iterative 32-bit divider between two requesters.
// Divide-by-zero is answered locally; each divide is bounded by a watchdog.
//
// state | meaning
// IDLE  | waiting for a request; grant decided combinationally from valids
// ISSUE | one-cycle start pulse to the divider, watchdog cleared
// WAIT  | watchdog counting until div_done or timeout
// RESP  | response held on rsp_* until rsp_ready
module div_arbiter #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_q,
    output logic [31:0] rsp_r,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] wd_cnt;
    logic          grant0;
    logic          grant1;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;

    // No grant while reset is held, so a handshake never lands on a cycle that is discarded.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sel_a      = grant1 ? req1_a : req0_a;
    assign sel_b      = grant1 ? req1_b : req0_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            div_start  <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_q      <= '0;
            rsp_r      <= '0;
            rsp_err    <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        div_a      <= sel_a;
                        div_b      <= sel_b;
                        rsp_id     <= grant1;
                        last_grant <= grant1;
                        if (sel_b == '0) begin
                            rsp_q     <= '1;
                            rsp_r     <= sel_a;
                            rsp_err   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // done has priority over a timeout landing in the same cycle
                    if (div_done) begin
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        rsp_q     <= '0;
                        rsp_r     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
